dc_sequence_scheduler: RTL and testbench

//  Run-time controller for the DC step sequencer. Holds a writable level table and arms/aborts runs.

---
 rtl/dc_sequence_scheduler.sv | 219 +++++++++++++++++++++
 tb/tb_dc_sequence_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dc_sequence_scheduler.sv
// DC step sequencer run-time controller: level table, hysteresis trigger, step/holdoff/pass FSM.
// Optional dwell-timer stepping is enabled with `define DC_SEQ_DWELL_EN (adds i_dwell_cycles).
module dc_sequence_scheduler #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16,
  parameter logic [DATA_W-1:0] HI_LVL = 16'h7FFF,
  parameter logic [DATA_W-1:0] LO_LVL = 16'h0000
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic signed [DATA_W-1:0] i_data_in,
  input  logic signed [DATA_W-1:0] i_hi_threshold,
  input  logic signed [DATA_W-1:0] i_lo_threshold,
  input  logic                     i_arm,
  input  logic                     i_abort,
  input  logic [ADDR_W-1:0]        i_last_addr,
  input  logic [7:0]               i_loops,
  input  logic [15:0]              i_holdoff,
  input  logic                     i_wr_en,
  input  logic [ADDR_W-1:0]        i_wr_addr,
  input  logic [DATA_W-1:0]        i_wr_data,
`ifdef DC_SEQ_DWELL_EN
  input  logic [31:0]              i_dwell_cycles,
`endif
  output logic signed [DATA_W-1:0] o_data_out_a,
  output logic [DATA_W-1:0]        o_data_out_b,
  output logic [ADDR_W-1:0]        o_level_addr,
  output logic                     o_step_pulse,
  output logic                     o_busy,
  output logic                     o_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_trig;
  logic                r_trig_dly;
  logic [ADDR_W-1:0]   r_level_addr;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [7:0]          r_pass;
  logic [7:0]          w_pass_nxt;
  logic [7:0]          w_pass_inc;
  logic [15:0]         r_hcnt;
  logic [15:0]         w_hcnt_nxt;
  logic                r_step_pulse;
  logic                w_step_nxt;
  logic                w_load0;
  logic                r_busy;
  logic                r_done;
  logic [DATA_W-1:0]   r_data_out_a;
  logic [DATA_W-1:0]   w_data_a_nxt;
  logic                w_rise;
  logic                w_step_req;
  logic                w_table_busy;
  logic [DATA_W-1:0]   r_mem [0:(2**ADDR_W)-1];

  assign w_rise       = r_trig & ~r_trig_dly;
  assign w_pass_inc   = r_pass + 8'd1;
  assign w_table_busy = (r_state == S_RUN) || (r_state == S_HOLD);

`ifdef DC_SEQ_DWELL_EN
  logic [31:0] r_dwell;
  logic        w_dwell_hit;

  assign w_dwell_hit = (r_state == S_RUN) && (i_dwell_cycles != 32'd0) &&
                       (r_dwell == (i_dwell_cycles - 32'd1));
  assign w_step_req  = w_rise | w_dwell_hit;

  // Dwell timer restarts on every entry to RUN and only counts while in RUN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_dwell <= 32'd0;
    end else if ((w_state_nxt == S_RUN) && (r_state != S_RUN)) begin
      r_dwell <= 32'd0;
    end else if (r_state == S_RUN) begin
      r_dwell <= r_dwell + 32'd1;
    end else begin
      r_dwell <= r_dwell;
    end
  end
`else
  assign w_step_req = w_rise;
`endif

  // Hysteresis trigger, tracked in every state so a level already high at Arm gives no rise
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_trig     <= 1'b0;
      r_trig_dly <= 1'b0;
    end else begin
      r_trig_dly <= r_trig;
      if (i_data_in >= i_hi_threshold) begin
        r_trig <= 1'b1;
      end else if (i_data_in < i_lo_threshold) begin
        r_trig <= 1'b0;
      end else begin
        r_trig <= r_trig;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_level_addr <= '0;
      r_pass       <= 8'd0;
      r_hcnt       <= 16'd0;
      r_step_pulse <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_data_out_a <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_level_addr <= w_addr_nxt;
      r_pass       <= w_pass_nxt;
      r_hcnt       <= w_hcnt_nxt;
      r_step_pulse <= w_step_nxt;
      r_busy       <= (w_state_nxt == S_RUN) || (w_state_nxt == S_HOLD);
      r_done       <= (w_state_nxt == S_DONE);
      r_data_out_a <= w_data_a_nxt;
    end
  end

  // Abort overrides everything; the final wrap of a bounded run goes to DONE without a step
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_level_addr;
    w_pass_nxt  = r_pass;
    w_hcnt_nxt  = r_hcnt;
    w_step_nxt  = 1'b0;
    w_load0     = 1'b0;
    if (i_abort) begin
      w_state_nxt = S_IDLE;
      w_addr_nxt  = '0;
      w_pass_nxt  = 8'd0;
      w_hcnt_nxt  = 16'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_arm) begin
            w_state_nxt = S_RUN;
            w_addr_nxt  = '0;
            w_pass_nxt  = 8'd0;
            w_load0     = 1'b1;
          end else begin
            w_state_nxt = r_state;
          end
        end
        S_RUN: begin
          if (w_step_req) begin
            w_hcnt_nxt = i_holdoff;
            if (r_level_addr == i_last_addr) begin
              if ((i_loops != 8'd0) && (w_pass_inc == i_loops)) begin
                w_state_nxt = S_DONE;
              end else begin
                w_state_nxt = S_HOLD;
                w_addr_nxt  = '0;
                w_pass_nxt  = w_pass_inc;
                w_step_nxt  = 1'b1;
              end
            end else begin
              w_state_nxt = S_HOLD;
              w_addr_nxt  = r_level_addr + ADDR_ONE;
              w_step_nxt  = 1'b1;
            end
          end else begin
            w_state_nxt = S_RUN;
          end
        end
        S_HOLD: begin
          if (r_hcnt == 16'd0) begin
            w_state_nxt = S_RUN;
          end else begin
            w_hcnt_nxt = r_hcnt - 16'd1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // table[0] is fetched on the Arm edge so the first level appears one cycle after Arm
  always_comb begin
    w_data_a_nxt = r_data_out_a;
    if (w_state_nxt == S_IDLE) begin
      w_data_a_nxt = '0;
    end else if (w_load0) begin
      w_data_a_nxt = r_mem[0];
    end else if (w_table_busy) begin
      w_data_a_nxt = r_mem[r_level_addr];
    end else begin
      w_data_a_nxt = r_data_out_a;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_wr_en && !w_table_busy) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_data_out_a = r_data_out_a;
  assign o_data_out_b = r_trig ? HI_LVL : LO_LVL;
  assign o_level_addr = r_level_addr;
  assign o_step_pulse = r_step_pulse;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule

// File: tb/tb_dc_sequence_scheduler.sv
// Directed scoreboard bench for dc_sequence_scheduler.
module tb_dc_sequence_scheduler;
  logic               clk = 1'b0;
  logic               reset;
  logic signed [15:0] data_in, hi_th, lo_th;
  logic               arm, abort_r, wr_en;
  logic [6:0]         last_addr, wr_addr;
  logic [7:0]         loops;
  logic [15:0]        holdoff, wr_data;
  logic signed [15:0] data_out_a;
  logic [15:0]        data_out_b;
  logic [6:0]         level_addr;
  logic               step_pulse, busy, done;
`ifdef DC_SEQ_DWELL_EN
  logic [31:0]        dwell_cycles;
`endif

  typedef struct {
    logic [6:0]         addr;
    logic signed [15:0] lvl;
  } exp_t;
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   tbl[4] = '{1000, 2000, -3000, 4000};

  always #5 clk = ~clk;

  dc_sequence_scheduler dut (
    .i_clk(clk), .i_reset(reset), .i_data_in(data_in),
    .i_hi_threshold(hi_th), .i_lo_threshold(lo_th),
    .i_arm(arm), .i_abort(abort_r), .i_last_addr(last_addr), .i_loops(loops),
    .i_holdoff(holdoff), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
`ifdef DC_SEQ_DWELL_EN
    .i_dwell_cycles(dwell_cycles),
`endif
    .o_data_out_a(data_out_a), .o_data_out_b(data_out_b), .o_level_addr(level_addr),
    .o_step_pulse(step_pulse), .o_busy(busy), .o_done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_pulse(input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      cyc();
      if (step_pulse) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    cyc();
    arm = 1'b0;
  endtask

  task automatic pulse_abort();
    abort_r = 1'b1;
    cyc();
    abort_r = 1'b0;
  endtask

  // One HI crossing: step pulse two cycles later, new level one cycle after that
  task automatic step_chk(input string tag);
    exp_t e;
    int   lat;
    data_in = 16'sd200;
    wait_pulse(6, lat);
    chk({tag, "_lat"}, lat, 32'd2);
    e = exp_q.pop_front();
    chk({tag, "_addr"}, {25'd0, level_addr}, {25'd0, e.addr});
    cyc();
    chk({tag, "_lvl"}, data_out_a, e.lvl);
    data_in = -16'sd200;
    cyc(2);
  endtask

  // Two single-cycle HI excursions gap cycles apart; counts resulting steps
  task automatic edge_pair(input int gap, output int cnt);
    cnt = 0;
    for (int i = 0; i < gap + 30; i++) begin
      data_in = (i == 0 || i == gap) ? 16'sd200 : -16'sd200;
      cyc();
      if (step_pulse) cnt++;
    end
  endtask

  initial begin
    int cnt, lat, total;
    int vals[5];
    logic [15:0] expb[5];
    exp_t e;
    vals = '{150, 0, 150, -150, 150};
    expb = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF};
    reset = 1'b1; data_in = -16'sd200; hi_th = 16'sd100; lo_th = -16'sd100;
    arm = 1'b0; abort_r = 1'b0; wr_en = 1'b0; wr_addr = 7'd0; wr_data = 16'd0;
    last_addr = 7'd3; loops = 8'd1; holdoff = 16'd0;
`ifdef DC_SEQ_DWELL_EN
    dwell_cycles = 32'd0;
`endif
    cyc(2);
    chk("rst_a", data_out_a, 32'd0);
    chk("rst_b", {16'd0, data_out_b}, 32'd0);
    chk("rst_addr", {25'd0, level_addr}, 32'd0);
    chk("rst_flags", {29'd0, step_pulse, busy, done}, 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) wr(7'(k), 16'(tbl[k]));

    // Test 1: one pass over four entries, fourth crossing ends the run
    pulse_arm();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_a0", data_out_a, 32'(tbl[0]));
    for (int k = 1; k < 4; k++) begin
      e.addr = 7'(k); e.lvl = 16'(tbl[k]);
      exp_q.push_back(e);
    end
    for (int k = 1; k < 4; k++) step_chk($sformatf("t1_s%0d", k));
    data_in = 16'sd200;
    cyc(2);
    chk("t1_done", {29'd0, step_pulse, busy, done}, 32'd1);
    cyc();
    chk("t1_hold", data_out_a, 32'(tbl[3]));
    data_in = -16'sd200;
    cyc(4);
    chk("t1_hold2", data_out_a, 32'(tbl[3]));

    // Test 2: hysteresis, re-armed from DONE
    pulse_arm();
    chk("t2_rearm", {level_addr, busy, done}, {23'd0, 7'd0, 1'b1, 1'b0});
    total = 0;
    for (int k = 0; k < 5; k++) begin
      data_in = 16'(vals[k]);
      for (int j = 0; j < 4; j++) begin
        cyc();
        if (step_pulse) total++;
      end
      chk($sformatf("t2_b%0d", k), {16'd0, data_out_b}, {16'd0, expb[k]});
    end
    chk("t2_steps", total, 32'd2);
    chk("t2_addr", {25'd0, level_addr}, 32'd2);

    // Test 3: holdoff blanking; 11-gap lands on the last HOLD cycle
    data_in = -16'sd200; loops = 8'd0; holdoff = 16'd10;
    pulse_abort();
    pulse_arm();
    edge_pair(5, cnt);
    chk("t3_gap5", cnt, 32'd1);
    edge_pair(12, cnt);
    chk("t3_gap12", cnt, 32'd2);
    edge_pair(11, cnt);
    chk("t3_gap11", cnt, 32'd1);
    chk("t3_addr", {25'd0, level_addr}, 32'd0);

    // Test 4: infinite loops over two entries
    last_addr = 7'd1; holdoff = 16'd0;
    pulse_abort();
    pulse_arm();
    for (int k = 0; k < 5; k++) begin
      e.addr = 7'((k + 1) % 2); e.lvl = 16'(tbl[(k + 1) % 2]);
      exp_q.push_back(e);
    end
    for (int k = 0; k < 5; k++) begin
      step_chk($sformatf("t4_s%0d", k));
      chk($sformatf("t4_nodone%0d", k), {31'd0, done}, 32'd0);
    end

    // Test 5: write while busy dropped, Abort beats Arm
    wr(7'd0, 16'd7777);
    abort_r = 1'b1; arm = 1'b1;
    cyc();
    abort_r = 1'b0; arm = 1'b0;
    chk("t5_idle", {data_out_a, 9'd0, level_addr}, 32'd0);
    chk("t5_flags", {30'd0, busy, done}, 32'd0);
    cyc(2);
    chk("t5_noarm", {31'd0, busy}, 32'd0);
    pulse_arm();
    chk("t5_tbl0", data_out_a, 32'(tbl[0]));
    pulse_abort();
    wr(7'd0, 16'd1234);
    pulse_arm();
    chk("t5_wr_idle", data_out_a, 32'd1234);

    // Reset mid-run stops everything
    data_in = 16'sd200;
    cyc(2);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rst_mid", {data_out_b, data_out_a}, 32'd0);
    chk("rst_mid_st", {level_addr, step_pulse, busy}, 32'd0);
    cnt = 0;
    for (int j = 0; j < 6; j++) begin
      cyc();
      if (step_pulse) cnt++;
    end
    chk("rst_mid_nostep", cnt, 32'd0);
    data_in = -16'sd200;
    cyc(3);

`ifdef DC_SEQ_DWELL_EN
    // Test 6: dwell stepping; period 8 + holdoff(2) + 1; coincident rise gives one step
    dwell_cycles = 32'd8; holdoff = 16'd2; last_addr = 7'd3; loops = 8'd0;
    pulse_arm();
    wait_pulse(20, lat);
    chk("t6_first", lat, 32'd8);
    wait_pulse(20, lat);
    chk("t6_period", lat, 32'd11);
    cyc(9);
    data_in = 16'sd200;
    cnt = 0;
    for (int j = 0; j < 4; j++) begin
      cyc();
      if (step_pulse) cnt++;
    end
    chk("t6_coinc", cnt, 32'd1);
    data_in = -16'sd200;
    wait_pulse(20, lat);
    chk("t6_after", lat, 32'd9);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
